delay_meter: RTL and testbench

Measures the latency of a single-bit delay path, such as a shift-register delay line, in clock cycles. It drives a one-cycle probe pulse into the path input and listens for that pulse on the path output. Before probing, it flushes the path by requiring a quiet interval on the echo input. The block sits next to the delay path under test in lab/self-test designs and reports the measured delay or a timeout.

---
 rtl/delay_meter.sv | 130 +++++++++++++
 tb/tb_delay_meter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/delay_meter.sv
// delay_meter: measures the latency of a single-bit delay path by flushing it,
// sending one probe pulse and counting cycles until the echo returns.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; result outputs hold the last measurement
// FLUSH | waiting for MAX_DELAY consecutive quiet echo cycles
// PROBE | probe_o high for exactly one cycle
// WAIT  | counting cycles until the echo arrives or MAX_DELAY expires
module delay_meter #(
  parameter  int MAX_DELAY = 64,
  localparam int D_W       = $clog2(MAX_DELAY + 1)
) (
  input  logic           clk_i,
  input  logic           srst_i,
  input  logic           start_i,
  input  logic           echo_i,
  output logic           probe_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [D_W-1:0] delay_o,
  output logic           timeout_o
);

  localparam int G_W = $clog2(4 * MAX_DELAY + 1);
  localparam logic [D_W-1:0] MAX_C   = D_W'(MAX_DELAY);
  localparam logic [G_W-1:0] GUARD_C = G_W'(4 * MAX_DELAY);

  typedef enum logic [1:0] {IDLE, FLUSH, PROBE, WAIT} state_t;

  state_t         state_q, state_d;
  logic [D_W-1:0] quiet_q, quiet_d;
  logic [G_W-1:0] guard_q, guard_d;
  logic [D_W-1:0] wait_q,  wait_d;
  logic           fin, fin_to, clr;
  logic [D_W-1:0] fin_delay;
  logic [D_W-1:0] quiet_inc;
  logic [G_W-1:0] guard_inc;

  assign quiet_inc = quiet_q + D_W'(1);
  assign guard_inc = guard_q + G_W'(1);
  assign busy_o    = (state_q != IDLE);

  // Next-state, counter updates and result capture strobes.
  always_comb begin
    state_d   = state_q;
    quiet_d   = quiet_q;
    guard_d   = guard_q;
    wait_d    = wait_q;
    fin       = 1'b0;
    fin_to    = 1'b0;
    fin_delay = '0;
    clr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FLUSH;
          quiet_d = '0;
          guard_d = '0;
          wait_d  = '0;
          clr     = 1'b1;
        end
      end
      FLUSH: begin
        quiet_d = echo_i ? '0 : quiet_inc;
        guard_d = guard_inc;
        // A clean quiet window wins over the guard expiring on the same cycle.
        if (!echo_i && quiet_inc == MAX_C) begin
          state_d = PROBE;
        end else if (guard_inc == GUARD_C) begin
          state_d = IDLE;
          fin     = 1'b1;
          fin_to  = 1'b1;
        end
      end
      PROBE: begin
        if (echo_i) begin
          state_d = IDLE;
          fin     = 1'b1;
        end else begin
          state_d = WAIT;
          wait_d  = D_W'(1);
        end
      end
      WAIT: begin
        if (echo_i) begin
          state_d   = IDLE;
          fin       = 1'b1;
          fin_delay = wait_q;
        end else if (wait_q == MAX_C) begin
          state_d = IDLE;
          fin     = 1'b1;
          fin_to  = 1'b1;
        end else begin
          wait_d = wait_q + D_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset abandons any measurement.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      quiet_q   <= '0;
      guard_q   <= '0;
      wait_q    <= '0;
      probe_o   <= 1'b0;
      done_o    <= 1'b0;
      delay_o   <= '0;
      timeout_o <= 1'b0;
    end else begin
      state_q <= state_d;
      quiet_q <= quiet_d;
      guard_q <= guard_d;
      wait_q  <= wait_d;
      probe_o <= (state_d == PROBE);
      done_o  <= fin;
      if (clr) begin
        delay_o   <= '0;
        timeout_o <= 1'b0;
      end else if (fin) begin
        delay_o   <= fin_delay;
        timeout_o <= fin_to;
      end
    end
  end

endmodule

// File: tb/tb_delay_meter.sv
// Bench for delay_meter with MAX_DELAY=16: a behavioural delay path model
// drives echo_i, expected results are queued per measurement and a monitor
// compares them whenever done_o pulses.
module tb_delay_meter;

  localparam int MAXD = 16;
  localparam int D_W  = $clog2(MAXD + 1);

  logic           clk_i = 1'b0;
  logic           srst_i = 1'b1;
  logic           start_i = 1'b0;
  logic           echo_i;
  logic           probe_o, busy_o, done_o, timeout_o;
  logic [D_W-1:0] delay_o;

  delay_meter #(.MAX_DELAY(MAXD)) dut (
    .clk_i(clk_i), .srst_i(srst_i), .start_i(start_i), .echo_i(echo_i),
    .probe_o(probe_o), .busy_o(busy_o), .done_o(done_o),
    .delay_o(delay_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int cyc; int dly; bit to;} exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;
  int mode = 0;          // 0 tie0, 1 tie1, 2 shift line, 3 loopback
  int len = 1;
  int pulse_cyc = -1;
  int probe_cnt = 0;
  int probe_cyc = -1;
  logic [31:0] sr = '0;
  logic base;

  // Cycle counter and the shift-register delay line fed by probe_o.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    sr  <= {sr[30:0], probe_o};
  end

  // Path model.
  always_comb begin
    base = 1'b0;
    case (mode)
      1: base = 1'b1;
      2: base = sr[len-1];
      3: base = probe_o;
      default: base = 1'b0;
    endcase
    echo_i = base | (cyc == pulse_cyc);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Probe observer.
  always @(negedge clk_i) begin
    if (probe_o) begin
      probe_cnt++;
      probe_cyc = cyc;
    end
  end

  // Scoreboard monitor: compares every done_o pulse against the queue head.
  always @(negedge clk_i) begin
    if (done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc - t0, e.cyc - t0);
        chk("delay", int'(delay_o), e.dly);
        chk("timeout", int'(timeout_o), int'(e.to));
        chk("busy_at_done", int'(busy_o), 0);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic run(input int m, input int l, input int pulse_off,
                     input int restart_off, input int done_off,
                     input int dly, input bit to, input int probe_off);
    exp_t e;
    @(posedge clk_i);
    #1;
    mode = m;
    len = l;
    t0 = cyc;
    pulse_cyc = (pulse_off >= 0) ? t0 + pulse_off : -1;
    probe_cnt = 0;
    e.cyc = t0 + done_off;
    e.dly = dly;
    e.to  = to;
    q.push_back(e);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("busy_after_start", int'(busy_o), 1);
    if (restart_off >= 0) begin
      wait_until(t0 + restart_off);
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
    end
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk_i);
    if (q.size() != 0) begin
      chk("done_wait_expired", 0, 1);
      q.delete();
    end
    if (probe_off < 0) begin
      chk("probe_count", probe_cnt, 0);
    end else begin
      chk("probe_count", probe_cnt, 1);
      chk("probe_cycle", probe_cyc - t0, probe_off);
    end
    pulse_cyc = -1;
    repeat (40) @(posedge clk_i);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_probe", int'(probe_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_delay", int'(delay_o), 0);
    chk("rst_timeout", int'(timeout_o), 0);
    srst_i = 1'b0;
    repeat (2) @(posedge clk_i);

    //  mode len pulse restart done dly to probe
    run(2, 10, -1, -1, 28, 10, 1'b0, 17);   // 10-cycle delay line
    run(3,  1, -1, -1, 18,  0, 1'b0, 17);   // combinational loopback
    run(0,  1, -1, -1, 34,  0, 1'b1, 17);   // no echo
    run(1,  1, -1, -1, 65,  0, 1'b1, -1);   // stuck-high echo, flush timeout
    run(2,  3,  5,  8, 26,  3, 1'b0, 22);   // quiet restart, ignored re-start
    run(2, 16, -1, -1, 34, 16, 1'b0, 17);   // longest measurable delay

    // Reset in WAIT abandons the measurement without a done pulse.
    @(posedge clk_i);
    #1;
    mode = 2;
    len = 10;
    t0 = cyc;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_until(t0 + 20);
    srst_i = 1'b1;
    @(posedge clk_i);
    #1;
    srst_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_probe", int'(probe_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    chk("mid_rst_delay", int'(delay_o), 0);
    chk("mid_rst_timeout", int'(timeout_o), 0);
    repeat (40) @(posedge clk_i);

    run(2, 10, -1, -1, 28, 10, 1'b0, 17);   // normal measurement after reset

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
